thread_insn_queue: RTL

Per-thread instruction queue sitting directly upstream of the SMT issue scheduler; one instance per hardware thread (four total). Accepts up to four decoded 100-bit instructions per cycle from decode and presents the four oldest entries, with valid bits, to the scheduler. Pops entries according to the scheduler's per-thread stall/advance response in the same cycle. Supports a synchronous flush for branch redirect.

---
 rtl/thread_insn_queue_pkg.sv | 29 ++
 rtl/thread_insn_queue_if.sv | 27 ++
 rtl/thread_insn_queue.sv | 102 ++++++++++
 3 files changed

// File: rtl/thread_insn_queue_pkg.sv
// Shared scheduler constants and types for the per-thread instruction queue.
// The issue scheduler imports the same package.
package thread_insn_queue_pkg;

    localparam int INSN_WIDTH       = 100;
    localparam int ADDR_WIDTH       = 22;
    localparam int BUNDLE_BIT       = 99;
    localparam int IS_BRANCH_OFFSET = 9;
    localparam int IS_MEM_OFFSET    = 1 + 8 + 1 + ADDR_WIDTH + 1;
    localparam int NUM_THREADS      = 4;
    localparam int TID_WIDTH        = 2;

    localparam int DEPTH     = 16;
    localparam int SLOTS     = 4;
    localparam int IDX_WIDTH = $clog2(DEPTH);
    localparam int PTR_WIDTH = $clog2(DEPTH) + 1;
    localparam int CNT_WIDTH = $clog2(DEPTH) + 1;

    typedef logic [INSN_WIDTH-1:0] insn_t;
    typedef logic [PTR_WIDTH-1:0]  ptr_t;
    typedef logic [IDX_WIDTH-1:0]  idx_t;
    typedef logic [CNT_WIDTH-1:0]  cnt_t;

    // Decode may present a count above the slot limit; anything past four is four.
    function automatic cnt_t clampWrCount(input logic [2:0] wrCount);
        return (wrCount > 3'd4) ? cnt_t'(SLOTS) : cnt_t'(wrCount);
    endfunction

endpackage

// File: rtl/thread_insn_queue_if.sv
// Decode push / scheduler pop bundle for one thread's instruction queue.
// master = decode+scheduler side, slave = the queue.
interface thread_insn_queue_if;
    import thread_insn_queue_pkg::*;

    logic                        i_Flush;
    logic [SLOTS*INSN_WIDTH-1:0] i_Wr_Insns;
    logic [2:0]                  i_Wr_Count;
    logic                        o_Wr_Ready;
    logic [SLOTS*INSN_WIDTH-1:0] o_Insns;
    logic [SLOTS-1:0]            o_Valid;
    logic                        i_Stall;
    logic [1:0]                  i_Advance;
    cnt_t                        o_Count;
    logic                        o_Overflow;

    modport master (
        output i_Flush, i_Wr_Insns, i_Wr_Count, i_Stall, i_Advance,
        input  o_Wr_Ready, o_Insns, o_Valid, o_Count, o_Overflow
    );

    modport slave (
        input  i_Flush, i_Wr_Insns, i_Wr_Count, i_Stall, i_Advance,
        output o_Wr_Ready, o_Insns, o_Valid, o_Count, o_Overflow
    );

endinterface

// File: rtl/thread_insn_queue.sv
// Per-thread circular instruction queue: up to four pushes and four pops per cycle,
// presenting the four oldest entries to the issue scheduler.
module thread_insn_queue
    import thread_insn_queue_pkg::*;
(
    input  logic                 i_Clk,
    input  logic                 i_Reset_n,
    thread_insn_queue_if.slave   q
);

    insn_t mem_q [DEPTH];

    ptr_t  head_q, head_d;
    ptr_t  tail_q, tail_d;
    cnt_t  count_q, count_d;
    logic  overflow_q, overflow_d;

    logic  wrReady;
    cnt_t  wrClamped;
    cnt_t  advCount;
    cnt_t  pushCount;
    cnt_t  popCount;
    idx_t  wrIdx [SLOTS];
    idx_t  rdIdx [SLOTS];

    // Ready looks only at the registered count, so a same-cycle pop never opens space.
    assign wrReady = (count_q <= cnt_t'(DEPTH - SLOTS));

    always_comb begin
        wrClamped  = clampWrCount(q.i_Wr_Count);
        advCount   = cnt_t'(q.i_Advance) + cnt_t'(1);
        pushCount  = (wrReady && !q.i_Flush) ? wrClamped : '0;
        popCount   = '0;
        if (!q.i_Stall) begin
            popCount = (advCount < count_q) ? advCount : count_q;
        end

        overflow_d = overflow_q;
        if ((q.i_Wr_Count != 3'd0) && !wrReady && !q.i_Flush) begin
            overflow_d = 1'b1;
        end

        head_d  = head_q + ptr_t'(popCount);
        tail_d  = tail_q + ptr_t'(pushCount);
        count_d = count_q + pushCount - popCount;
        if (q.i_Flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_comb begin
        for (int k = 0; k < SLOTS; k++) begin
            wrIdx[k] = tail_q[IDX_WIDTH-1:0] + idx_t'(k);
            rdIdx[k] = head_q[IDX_WIDTH-1:0] + idx_t'(k);
        end
    end

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is deliberately unreset; o_Valid masks whatever it holds.
    always_ff @(posedge i_Clk) begin
        for (int k = 0; k < SLOTS; k++) begin
            if (cnt_t'(k) < pushCount) begin
                mem_q[wrIdx[k]] <= q.i_Wr_Insns[k*INSN_WIDTH +: INSN_WIDTH];
            end
        end
    end

    always_comb begin
        q.o_Insns = '0;
        q.o_Valid = '0;
        for (int k = 0; k < SLOTS; k++) begin
            q.o_Insns[k*INSN_WIDTH +: INSN_WIDTH] = mem_q[rdIdx[k]];
            q.o_Valid[k] = (count_q > cnt_t'(k));
        end
    end

    assign q.o_Wr_Ready = wrReady;
    assign q.o_Count    = count_q;
    assign q.o_Overflow = overflow_q;

    occupancyBounded: assert property (
        @(posedge i_Clk) disable iff (!i_Reset_n) count_q <= cnt_t'(DEPTH));

    occupancyMatchesPointers: assert property (
        @(posedge i_Clk) disable iff (!i_Reset_n) count_q == cnt_t'(tail_q - head_q));

endmodule
